// File: rtl/div_unit.sv
// RV32M divide/remainder unit: radix-2 restoring divider on operand magnitudes,
// with sign fixup in one extra cycle and single-cycle fast paths for b==0 and overflow.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvs_q;
    logic [XLEN-1:0]   result_q;
    logic [CW-1:0]     cnt_q;
    logic              qneg_q;
    logic              rneg_q;
    logic              sel_rem_q;
    logic              resp_valid_q;

    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   quo_sh;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;
    logic              is_signed;
    logic              div_zero;
    logic              ovf;
    logic [XLEN-1:0]   fast_res;

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] abs_mag(input logic signed [XLEN-1:0] v);
        return (v < 0) ? neg($unsigned(v)) : $unsigned(v);
    endfunction

    // The shifted partial remainder carries one extra bit so the compare is a true unsigned one.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        quo_sh = {quo_q[XLEN-2:0], 1'b0};
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_d = rem_sh[XLEN-1:0] - dvs_q;
            quo_d = quo_sh | {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            rem_d = rem_sh[XLEN-1:0];
            quo_d = quo_sh;
        end
    end

    always_comb begin
        is_signed = ~op[0];
        div_zero  = (b == '0);
        ovf       = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
        // Overflow quotient equals the dividend itself (most negative value).
        if (div_zero) begin
            fast_res = op[1] ? a : {XLEN{1'b1}};
        end else begin
            fast_res = op[1] ? '0 : a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            sel_rem_q    <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        sel_rem_q <= op[1];
                        if (div_zero || ovf) begin
                            result_q     <= fast_res;
                            resp_valid_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= is_signed ? abs_mag($signed(a)) : a;
                            dvs_q   <= is_signed ? abs_mag($signed(b)) : b;
                            qneg_q  <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
                            rneg_q  <= is_signed & a[XLEN-1];
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (sel_rem_q) begin
                        result_q <= rneg_q ? neg(rem_q) : rem_q;
                    end else begin
                        result_q <= qneg_q ? neg(quo_q) : quo_q;
                    end
                    resp_valid_q <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign result     = result_q;

endmodule
